frac_div_ctrl: RTL
==================

FRAC_DIV_CTRL -- requirements
Module: frac_div_ctrl

Interface
REQ-001 The block SHALL have parameter INT_W, default 8, meaning the integer divide-ratio width.
REQ-002 The block SHALL have parameter FRAC_W, default 8, meaning the fractional divide-ratio width.
REQ-003 The block SHALL have parameter DEF_INT, default 4, meaning the integer ratio in use after reset.
REQ-004 The block SHALL have parameter DEF_FRAC, default 0, meaning the fractional ratio in use after reset.
REQ-005 The block SHALL have port clk_in, input, width 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, width 1, an asynchronous active-low reset (0 = reset asserted).
REQ-007 The block SHALL have port enable, input, width 1, which requests divided-clock generation.
REQ-008 The block SHALL have port cfg_valid, input, width 1, marking a configuration request.
REQ-009 The block SHALL have port cfg_int, input, width INT_W, the requested integer ratio.
REQ-010 The block SHALL have port cfg_frac, input, width FRAC_W, the requested fraction in units of 2^-FRAC_W.
REQ-011 The block SHALL have port cfg_ready, output, width 1, which is high when a request can be accepted.
REQ-012 The block SHALL have port cfg_err, output, width 1, a one-cycle pulse flagging a rejected request.
REQ-013 The block SHALL have port clk_out, output, width 1, the registered divided clock.
REQ-014 The block SHALL have port period_tick, output, width 1, a one-cycle pulse in the last cycle of each output period.
REQ-015 The block SHALL have port cur_ratio, output, width INT_W+1, the ratio of the current period.

Function
REQ-016 The block SHALL implement states IDLE and RUN.
REQ-017 In IDLE, the block SHALL hold the counter at 0 and drive clk_out=0 and period_tick=0.
REQ-018 IDLE SHALL go to RUN on the cycle after enable=1 is sampled.
REQ-019 RUN SHALL go to IDLE only after a period_tick cycle in which enable=0, so periods are never truncated.
REQ-020 In RUN, the counter cnt SHALL count 0..cur_ratio-1 and wrap to 0; period_tick SHALL be 1 when cnt==cur_ratio-1.
REQ-021 clk_out SHALL be 1 exactly in the RUN cycles where cnt < (cur_ratio>>1), and SHALL be driven from a flop (glitch-free).
REQ-022 Each new period, including the first after IDLE, SHALL compute sum = acc + frac at FRAC_W+1 bits.
REQ-023 For that period, cur_ratio SHALL be int+1 if sum has a carry and int otherwise, with acc <= sum mod 2^FRAC_W.
REQ-024 A handshake SHALL occur when cfg_valid and cfg_ready are both 1.
REQ-025 A request with cfg_int < 2 SHALL be rejected: cfg_err pulses on the next cycle and the stored configuration is unchanged.
REQ-026 A valid accepted request SHALL become pending, and cfg_ready SHALL be 0 while a request is pending.
REQ-027 In IDLE, a pending configuration SHALL be applied on the next cycle.
REQ-028 In RUN, a pending configuration SHALL be applied at the next period boundary, so the following period uses the new int/frac.
REQ-029 A request accepted in a period_tick cycle SHALL take effect for the immediately following period.
REQ-030 Applying a configuration SHALL clear acc to 0.
REQ-031 cfg_int = 2^INT_W-1 with a carry SHALL give cur_ratio = 2^INT_W without overflow.

Reset
REQ-032 Reset assertion, at any time including mid-period, SHALL immediately set the block to IDLE, with cnt=0, acc=0, no pending configuration, int=DEF_INT, frac=DEF_FRAC, and cur_ratio=DEF_INT.
REQ-033 While reset is asserted, the outputs SHALL be clk_out=0, period_tick=0, cfg_err=0 and cfg_ready=0.
REQ-034 cfg_ready SHALL be 1 from the first clock edge after reset deassertion.

Verification
REQ-035 Scenario: after reset, enable=1 with defaults -> clk_out period 4 cycles (2 high, 2 low), period_tick every 4th cycle, cur_ratio=4.
REQ-036 Scenario: cfg_int=4 and cfg_frac=128 loaded in IDLE, then enable=1 -> period lengths 4,5,4,5,... with 2 high cycles each; cur_ratio alternates 4/5.
REQ-037 Scenario: cfg_int=1 -> one-cycle cfg_err pulse, no change to cur_ratio, and cfg_ready stays 1.
REQ-038 Scenario: while running at 4, load cfg_int=6 at cnt=1 -> the current period completes at 4 cycles, the next period is 6 (3 high), and cfg_ready is 0 until the boundary.
REQ-039 Scenario: enable dropped at cnt=0 -> the period finishes, then IDLE with clk_out=0; re-enable resumes with acc=0.
REQ-040 Scenario: reset pulsed mid-period while running 6 -> outputs go to 0 at once and cur_ratio=4 after release.

Source files
------------

// File: rtl/frac_div_ctrl.sv
// Purpose : fractional clock divider; each output period lasts int or int+1 input cycles, chosen by a fraction accumulator.
// Latency : outputs are registered; a run starts the cycle after enable is sampled, and a config change takes effect at the next period start.
// Backpress: cfg_ready drops while a config is pending, and a request with cfg_int < 2 is dropped with a cfg_err pulse.
// Ports   : clk_in/reset (async, active-low) | enable | cfg_valid/cfg_ready/cfg_int/cfg_frac/cfg_err
//           | clk_out, period_tick, cur_ratio (ratio of the period in progress)
module frac_div_ctrl #(
  parameter int INT_W    = 8,
  parameter int FRAC_W   = 8,
  parameter int DEF_INT  = 4,
  parameter int DEF_FRAC = 0
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_valid,
  input  logic [INT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              clk_out,
  output logic              period_tick,
  output logic [INT_W:0]    cur_ratio
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [INT_W:0]      cnt;
  logic [FRAC_W-1:0]   acc;
  logic [INT_W-1:0]    int_r;
  logic [FRAC_W-1:0]   frac_r;
  logic                pend;
  logic [INT_W-1:0]    pend_int;
  logic [FRAC_W-1:0]   pend_frac;

  logic                accept;
  logic                reject;
  logic                start;
  logic                stop;
  logic [INT_W-1:0]    sel_int;
  logic [FRAC_W-1:0]   sel_frac;
  logic [FRAC_W-1:0]   sel_acc;
  logic [FRAC_W:0]     sum;
  logic [INT_W:0]      next_ratio;
  state_t              state_n;
  logic [INT_W:0]      cnt_n;
  logic [INT_W:0]      ratio_n;
  logic                pend_n;

  always_comb begin
    accept   = cfg_valid & cfg_ready & (cfg_int >= INT_W'(2));
    reject   = cfg_valid & cfg_ready & (cfg_int <  INT_W'(2));
    // A period starts out of IDLE, or after a tick while still enabled.
    start    = ((state == IDLE) & enable) | ((state == RUN) & period_tick & enable);
    stop     = (state == RUN) & period_tick & ~enable;

    // New config wins at a period start: a pending one, or one accepted in
    // this very cycle (lets a request in the tick cycle hit the next period).
    sel_int  = pend ? pend_int  : (accept ? cfg_int  : int_r);
    sel_frac = pend ? pend_frac : (accept ? cfg_frac : frac_r);
    sel_acc  = (pend | accept) ? '0 : acc;

    sum        = {1'b0, sel_acc} + {1'b0, sel_frac};
    // One extra bit so int = 2^INT_W-1 plus carry does not wrap.
    next_ratio = {1'b0, sel_int} + {{INT_W{1'b0}}, sum[FRAC_W]};

    state_n = state;
    cnt_n   = cnt;
    ratio_n = cur_ratio;
    if (start) begin
      state_n = RUN;
      cnt_n   = '0;
      ratio_n = next_ratio;
    end else if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == RUN) begin
      cnt_n   = cnt + (INT_W+1)'(1);
    end

    if (start || ((state == IDLE) && pend))
      pend_n = 1'b0;
    else if (accept)
      pend_n = 1'b1;
    else
      pend_n = pend;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      int_r       <= INT_W'(DEF_INT);
      frac_r      <= FRAC_W'(DEF_FRAC);
      pend        <= 1'b0;
      pend_int    <= INT_W'(DEF_INT);
      pend_frac   <= FRAC_W'(DEF_FRAC);
      cur_ratio   <= (INT_W+1)'(DEF_INT);
      clk_out     <= 1'b0;
      period_tick <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_ready   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cur_ratio <= ratio_n;
      pend      <= pend_n;
      cfg_ready <= ~pend_n;
      cfg_err   <= reject;

      // Outputs are computed from next-cycle counter/ratio so they come
      // straight off flops and line up with the cnt they describe.
      clk_out     <= (state_n == RUN) && (cnt_n < (ratio_n >> 1));
      period_tick <= (state_n == RUN) && (cnt_n == ratio_n - (INT_W+1)'(1));

      if (start) begin
        int_r  <= sel_int;
        frac_r <= sel_frac;
        acc    <= sum[FRAC_W-1:0];
      end else begin
        // A fresh run always begins from a zero accumulator.
        if (stop)
          acc <= '0;
        if ((state == IDLE) && pend) begin
          int_r  <= pend_int;
          frac_r <= pend_frac;
          acc    <= '0;
        end else if (accept) begin
          pend_int  <= cfg_int;
          pend_frac <= cfg_frac;
        end
      end
    end
  end

endmodule
